// File: rtl/timer_periph_pkg.sv
// Shared constants, register map and types for the timer peripheral.
package timer_periph_pkg;

   localparam int P_ADDR_WIDTH = 8;
   localparam int P_DATA_WIDTH = 32;

   localparam logic [P_ADDR_WIDTH-1:0] ADDR_CTRL   = 8'h00;
   localparam logic [P_ADDR_WIDTH-1:0] ADDR_LOAD   = 8'h04;
   localparam logic [P_ADDR_WIDTH-1:0] ADDR_STATUS = 8'h08;
   localparam logic [P_ADDR_WIDTH-1:0] ADDR_COUNT  = 8'h0C;

   localparam int CTRL_START_BIT  = 0;
   localparam int CTRL_RELOAD_BIT = 1;
   localparam int CTRL_IRQEN_BIT  = 2;
   localparam int CTRL_PRESC_LSB  = 8;
   localparam int CTRL_PRESC_W    = 8;

   typedef enum logic {S_IDLE, S_ACK} bus_state_t;

   typedef struct packed {
      logic [CTRL_PRESC_W-1:0] presc;
      logic                    irq_en;
      logic                    reload_en;
      logic                    start;
   } ctrl_t;

   // CTRL register image as seen on the bus; unused bits read 0.
   function automatic logic [P_DATA_WIDTH-1:0] ctrl_to_word(input ctrl_t c);
      logic [P_DATA_WIDTH-1:0] w;
      w = '0;
      w[CTRL_START_BIT]                   = c.start;
      w[CTRL_RELOAD_BIT]                  = c.reload_en;
      w[CTRL_IRQEN_BIT]                   = c.irq_en;
      w[CTRL_PRESC_LSB +: CTRL_PRESC_W]   = c.presc;
      return w;
   endfunction

   function automatic ctrl_t word_to_ctrl(input logic [P_DATA_WIDTH-1:0] w);
      ctrl_t c;
      c.start     = w[CTRL_START_BIT];
      c.reload_en = w[CTRL_RELOAD_BIT];
      c.irq_en    = w[CTRL_IRQEN_BIT];
      c.presc     = w[CTRL_PRESC_LSB +: CTRL_PRESC_W];
      return c;
   endfunction

endpackage

// File: rtl/timer_periph_if.sv
// Timer bus: single-beat req/gnt register access.
interface timer_periph_if;
   import timer_periph_pkg::*;

   logic                    req;
   logic                    gnt;
   logic                    write_en;
   logic [P_ADDR_WIDTH-1:0] addr;
   logic [P_DATA_WIDTH-1:0] wdata;
   logic [P_DATA_WIDTH-1:0] rdata;

   modport master (output req, write_en, addr, wdata, input gnt, rdata);
   modport slave  (input req, write_en, addr, wdata, output gnt, rdata);
endinterface

// File: rtl/timer_periph_counter.sv
// Prescaled down-counter with one-shot / auto-reload expiry.
module timer_periph_counter
   import timer_periph_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_start,
   input  logic                    i_reload_en,
   input  logic [CTRL_PRESC_W-1:0] i_presc,
   input  logic [P_DATA_WIDTH-1:0] i_load,
   input  logic                    i_start_pulse,
   output logic [P_DATA_WIDTH-1:0] o_count,
   output logic                    o_expire_pulse,
   output logic                    o_oneshot_done
);

   localparam logic [P_DATA_WIDTH-1:0] ONE = 1;

   logic [CTRL_PRESC_W-1:0] r_presc_cnt;
   logic [P_DATA_WIDTH-1:0] r_count;
   logic                    w_tick;

   // >= keeps the tick period sane if presc is lowered mid-count
   assign w_tick         = i_start && (r_presc_cnt >= i_presc);
   assign o_expire_pulse = w_tick && (r_count == '0);
   assign o_oneshot_done = o_expire_pulse && !i_reload_en;
   assign o_count        = r_count;

   // Prescaler: restarts on start, on stop and after every tick
   always_ff @(posedge clk) begin
      if (reset || i_start_pulse || !i_start || w_tick) r_presc_cnt <= '0;
      else                                              r_presc_cnt <= r_presc_cnt + 8'd1;
   end

   // Counter: load on start, decrement per tick, reload or hold at 0 on expiry
   always_ff @(posedge clk) begin
      if (reset)              r_count <= '0;
      else if (i_start_pulse) r_count <= i_load;
      else if (w_tick) begin
         if (r_count != '0)    r_count <= r_count - ONE;
         else if (i_reload_en) r_count <= i_load;
      end
   end

endmodule

// File: rtl/timer_periph.sv
// Timer peripheral top: bus FSM, register file, counter and irq register.
module timer_periph
   import timer_periph_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   timer_periph_if.slave  bus,
   output logic           o_irq
);

   bus_state_t              r_state, w_next;
   ctrl_t                   r_ctrl;
   logic [P_DATA_WIDTH-1:0] r_load, r_rdata, w_rd_mux, w_count;
   logic                    r_expired, r_irq;
   logic                    w_acc, w_wr, w_rd, w_gnt;
   logic                    w_wr_ctrl, w_wr_load, w_wr_status;
   logic                    w_start_pulse, w_expire, w_oneshot_done;

   assign w_acc         = (r_state == S_IDLE) && bus.req;
   assign w_wr          = w_acc && bus.write_en;
   assign w_rd          = w_acc && !bus.write_en;
   assign w_wr_ctrl     = w_wr && (bus.addr == ADDR_CTRL);
   assign w_wr_load     = w_wr && (bus.addr == ADDR_LOAD);
   assign w_wr_status   = w_wr && (bus.addr == ADDR_STATUS);
   assign w_start_pulse = w_wr_ctrl && bus.wdata[CTRL_START_BIT] && !r_ctrl.start;

   // Bus FSM state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Bus FSM next state; gnt is a pure function of state
   always_comb begin
      w_next = r_state;
      w_gnt  = 1'b0;
      case (r_state)
         S_IDLE: if (bus.req) w_next = S_ACK;
         S_ACK: begin
            w_gnt  = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Read mux; full-address compare also rejects misaligned offsets
   always_comb begin
      w_rd_mux = '0;
      case (bus.addr)
         ADDR_CTRL:   w_rd_mux = ctrl_to_word(r_ctrl);
         ADDR_LOAD:   w_rd_mux = r_load;
         ADDR_STATUS: w_rd_mux = {{(P_DATA_WIDTH-1){1'b0}}, r_expired};
         ADDR_COUNT:  w_rd_mux = w_count;
         default:     w_rd_mux = '0;
      endcase
   end

   // CTRL/LOAD writes; a software CTRL write beats the one-shot start clear
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ctrl <= '0;
         r_load <= '0;
      end else begin
         if (w_wr_ctrl)           r_ctrl       <= word_to_ctrl(bus.wdata);
         else if (w_oneshot_done) r_ctrl.start <= 1'b0;
         if (w_wr_load)           r_load       <= bus.wdata;
      end
   end

   // Sticky expiry flag (expiry beats W1C) and registered irq
   always_ff @(posedge clk) begin
      if (reset) begin
         r_expired <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         if (w_expire)                             r_expired <= 1'b1;
         else if (w_wr_status && bus.wdata[0])     r_expired <= 1'b0;
         r_irq <= r_expired && r_ctrl.irq_en;
      end
   end

   // Read data captured at acceptance and held until the next read
   always_ff @(posedge clk) begin
      if (reset)     r_rdata <= '0;
      else if (w_rd) r_rdata <= w_rd_mux;
   end

   timer_periph_counter u_counter (
      .clk            (clk),
      .reset          (reset),
      .i_start        (r_ctrl.start),
      .i_reload_en    (r_ctrl.reload_en),
      .i_presc        (r_ctrl.presc),
      .i_load         (r_load),
      .i_start_pulse  (w_start_pulse),
      .o_count        (w_count),
      .o_expire_pulse (w_expire),
      .o_oneshot_done (w_oneshot_done)
   );

   assign bus.gnt   = w_gnt;
   assign bus.rdata = r_rdata;
   assign o_irq     = r_irq;

endmodule

// File: tb/tb_timer_periph.sv
// Bench for timer_periph: directed bus traffic, read data checked by a scoreboard monitor.
module tb_timer_periph;
   import timer_periph_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic irq;
   int   checks = 0;
   int   failures = 0;

   logic [31:0] exp_q[$];
   string       name_q[$];

   timer_periph_if bif();

   timer_periph dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif),
      .o_irq (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
      end
   endtask

   // One bus transaction; reads queue their expected rdata for the monitor
   task automatic xfer(input logic we, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input string nm);
      int n = 0;
      if (!we) begin
         exp_q.push_back(exp);
         name_q.push_back(nm);
      end
      bif.req = 1'b1; bif.write_en = we; bif.addr = a; bif.wdata = d;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!bif.gnt && n < 16);
      bif.req = 1'b0;
      check({nm, " gnt latency"}, 32'(n), 32'd1);
      @(posedge clk); #1;
      check({nm, " gnt width"}, 32'(bif.gnt), 32'd0);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input string nm);
      xfer(1'b1, a, d, 32'd0, nm);
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
      xfer(1'b0, a, 32'd0, exp, nm);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: compares rdata during every read grant
   initial forever begin : mon
      logic [31:0] e;
      string       nm;
      @(negedge clk);
      if (!reset && bif.gnt && !bif.write_en) begin
         if (exp_q.size() == 0) check("unexpected read gnt", 32'd1, 32'd0);
         else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, bif.rdata, e);
         end
      end
   end

   initial begin
      reset = 1'b1;
      bif.req = 1'b0; bif.write_en = 1'b0; bif.addr = '0; bif.wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset gnt", 32'(bif.gnt), 32'd0);
      check("reset irq", 32'(irq), 32'd0);
      check("reset rdata", bif.rdata, 32'd0);
      reset = 1'b0;

      // reset values
      rd(ADDR_CTRL,   32'd0, "rst CTRL");
      rd(ADDR_LOAD,   32'd0, "rst LOAD");
      rd(ADDR_STATUS, 32'd0, "rst STATUS");
      rd(ADDR_COUNT,  32'd0, "rst COUNT");

      // one-shot, presc=0; start accepted at edge N, reads at N+2, N+4, N+6
      wr(ADDR_LOAD, 32'd5, "os LOAD");
      wr(ADDR_CTRL, 32'h1, "os CTRL");
      rd(ADDR_COUNT,  32'd4, "os COUNT@N+2");
      rd(ADDR_COUNT,  32'd2, "os COUNT@N+4");
      rd(ADDR_COUNT,  32'd0, "os COUNT@N+6");
      rd(ADDR_STATUS, 32'd1, "os STATUS");
      rd(ADDR_CTRL,   32'd0, "os CTRL cleared");
      rd(ADDR_COUNT,  32'd0, "os COUNT holds");
      check("os irq masked", 32'(irq), 32'd0);
      wr(ADDR_STATUS, 32'd1, "os W1C");
      rd(ADDR_STATUS, 32'd0, "os STATUS cleared");

      // reload, presc=3, irq: start at T, expiries at T+12, T+24
      wr(ADDR_LOAD, 32'd2, "rl LOAD");
      wr(ADDR_CTRL, 32'h0000_0307, "rl CTRL");
      cyc(10);
      check("rl irq T+11", 32'(irq), 32'd0);
      cyc(1);
      check("rl irq T+12", 32'(irq), 32'd0);
      cyc(1);
      check("rl irq T+13", 32'(irq), 32'd1);
      rd(ADDR_STATUS, 32'd1, "rl STATUS set");
      wr(ADDR_STATUS, 32'd1, "rl W1C");
      check("rl irq dropped", 32'(irq), 32'd0);
      rd(ADDR_STATUS, 32'd0, "rl STATUS cleared");
      rd(ADDR_COUNT,  32'd1, "rl COUNT@T+20");
      cyc(2);
      wr(ADDR_STATUS, 32'd1, "W1C at expiry");
      rd(ADDR_STATUS, 32'd1, "expiry beats W1C");
      wr(ADDR_CTRL, 32'd0, "stop");
      wr(ADDR_STATUS, 32'd1, "stop W1C");
      rd(ADDR_STATUS, 32'd0, "stop STATUS");

      // unmapped and read-only accesses
      wr(8'h10, 32'hDEAD_BEEF, "wr 0x10");
      rd(8'h10, 32'd0, "rd 0x10");
      wr(8'h05, 32'h0000_1234, "wr 0x05");
      rd(8'h05, 32'd0, "rd 0x05");
      rd(ADDR_LOAD,  32'd2, "LOAD untouched");
      rd(ADDR_CTRL,  32'd0, "CTRL untouched");
      rd(ADDR_COUNT, 32'd1, "COUNT stopped");
      wr(ADDR_COUNT, 32'h0000_FFFF, "wr COUNT");
      rd(ADDR_COUNT, 32'd1, "COUNT read-only");

      // reset with a pending request aborts it
      wr(ADDR_CTRL, 32'h0000_0306, "pre-rst CTRL");
      bif.req = 1'b1; bif.write_en = 1'b1; bif.addr = ADDR_LOAD; bif.wdata = 32'h55;
      reset = 1'b1;
      cyc(1);
      check("rst abort gnt a", 32'(bif.gnt), 32'd0);
      cyc(1);
      check("rst abort gnt b", 32'(bif.gnt), 32'd0);
      bif.req = 1'b0;
      reset = 1'b0;
      rd(ADDR_LOAD,   32'd0, "post-rst LOAD");
      rd(ADDR_CTRL,   32'd0, "post-rst CTRL");
      rd(ADDR_STATUS, 32'd0, "post-rst STATUS");
      rd(ADDR_COUNT,  32'd0, "post-rst COUNT");
      wr(ADDR_LOAD, 32'h55, "reissue LOAD");
      rd(ADDR_LOAD, 32'h55, "reissue LOAD rd");

      cyc(4);
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
